// File: rtl/noc_flit_rx_axis.sv
// -----------------------------------------------------------------------------
// noc_flit_rx_axis
//
// Receiving end of a NoC router output port. Flits arrive under credit flow
// control, land in a small receive FIFO, and are reassembled SERIALIZATION_FACTOR
// at a time into one AXI-Stream beat. The beat goes out on a registered AXIS
// master. Each flit taken out of the FIFO returns one credit to the sender.
//
// Ports:
//   clk_noc          clock (NoC domain, no crossing)
//   rst_noc_sync     synchronous active-high reset
//   data_in          flit payload
//   dest_in          flit destination {tid, tdest}; used only on a beat's final flit
//   is_tail_in       last flit of a packet
//   send_in          flit valid, one cycle per flit
//   credit_out       one-cycle pulse per flit taken from the FIFO
//   axis_out_*       registered AXIS master (tvalid/tready/tdata/tlast/tid/tdest)
//   overflow_err     sticky: a flit arrived while the FIFO was full and was dropped
//
// AXIS handshake: a beat transfers on a cycle where tvalid and tready are both 1.
// Once tvalid is raised it stays high, with tdata/tlast/tid/tdest unchanged,
// until that transfer happens; a new beat may be loaded in the transfer cycle.
// -----------------------------------------------------------------------------
module noc_flit_rx_axis #(
    parameter int FLIT_WIDTH           = 32,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 4,
    parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH,
    parameter int SERIALIZATION_FACTOR = 1,
    parameter int TDATA_WIDTH          = FLIT_WIDTH * SERIALIZATION_FACTOR,
    parameter int FLIT_BUFFER_DEPTH    = 2
) (
    input  logic                   clk_noc,
    input  logic                   rst_noc_sync,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]  dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [TDATA_WIDTH-1:0] axis_out_tdata,
    output logic                   axis_out_tlast,
    output logic [TID_WIDTH-1:0]   axis_out_tid,
    output logic [TDEST_WIDTH-1:0] axis_out_tdest,
    output logic                   overflow_err
);

    localparam int PTR_W = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FLIT_BUFFER_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SERIALIZATION_FACTOR - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Receive FIFO storage. The array itself is not reset: emptiness is
    // carried entirely by the pointers and the occupancy count.
    logic [FLIT_WIDTH-1:0] mem_data [FLIT_BUFFER_DEPTH];
    logic [DEST_WIDTH-1:0] mem_dest [FLIT_BUFFER_DEPTH];
    logic                  mem_tail [FLIT_BUFFER_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [IDX_W-1:0]       idx;
    logic [TDATA_WIDTH-1:0] asm_reg;

    logic [FLIT_WIDTH-1:0]  head_data;
    logic [DEST_WIDTH-1:0]  head_dest;
    logic                   head_tail;
    logic                   empty;
    logic                   full;
    logic                   head_final;
    logic                   out_free;
    logic                   pop;
    logic                   push;
    logic                   drop;
    logic [TDATA_WIDTH-1:0] merged;

    assign head_data = mem_data[rd_ptr];
    assign head_dest = mem_dest[rd_ptr];
    assign head_tail = mem_tail[rd_ptr];

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    // A flit closes the beat either because the packet ends or because the
    // assembly register is about to be completely filled.
    assign head_final = head_tail || (idx == LAST_IDX);

    // The output register can take a new beat if it is empty or being drained.
    assign out_free = !axis_out_tvalid || axis_out_tready;

    // Non-final flits never need the output register, so they drain freely.
    assign pop  = !empty && (!head_final || out_free);

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push = send_in && (!full || pop);
    assign drop = send_in && full && !pop;

    // Assembly contents with the head flit dropped into its slice. Slices above
    // idx are still zero because the assembly register clears after each beat.
    always_comb begin
        merged = asm_reg;
        merged[int'(idx) * FLIT_WIDTH +: FLIT_WIDTH] = head_data;
    end

    always_ff @(posedge clk_noc) begin
        if (push) begin
            mem_data[wr_ptr] <= data_in;
            mem_dest[wr_ptr] <= dest_in;
            mem_tail[wr_ptr] <= is_tail_in;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            idx             <= '0;
            asm_reg         <= '0;
            credit_out      <= 1'b0;
            overflow_err    <= 1'b0;
            axis_out_tvalid <= 1'b0;
            axis_out_tdata  <= '0;
            axis_out_tlast  <= 1'b0;
            axis_out_tid    <= '0;
            axis_out_tdest  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            credit_out <= pop;

            if (drop) begin
                overflow_err <= 1'b1;
            end

            if (pop && head_final) begin
                axis_out_tvalid <= 1'b1;
                axis_out_tdata  <= merged;
                axis_out_tlast  <= head_tail;
                axis_out_tid    <= head_dest[DEST_WIDTH-1:TDEST_WIDTH];
                axis_out_tdest  <= head_dest[TDEST_WIDTH-1:0];
                asm_reg         <= '0;
                idx             <= '0;
            end else begin
                if (pop) begin
                    asm_reg <= merged;
                    idx     <= idx + IDX_ONE;
                end
                if (axis_out_tvalid && axis_out_tready) begin
                    axis_out_tvalid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_flit_rx_axis.sv
// -----------------------------------------------------------------------------
// tb_noc_flit_rx_axis
//
// Drives two instances from shared inputs: one with SERIALIZATION_FACTOR=1 and
// one with SERIALIZATION_FACTOR=2 (both FIFO depth 2). Each scenario resets
// both and checks only the instance it targets.
// -----------------------------------------------------------------------------
module tb_noc_flit_rx_axis;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] data;
    logic [5:0]  dest;
    logic        tail;
    logic        send;
    logic        tready;

    logic        s1_credit, s1_tvalid, s1_tlast, s1_ovf;
    logic [31:0] s1_tdata;
    logic [1:0]  s1_tid;
    logic [3:0]  s1_tdest;

    logic        s2_credit, s2_tvalid, s2_tlast, s2_ovf;
    logic [63:0] s2_tdata;
    logic [1:0]  s2_tid;
    logic [3:0]  s2_tdest;

    noc_flit_rx_axis #(.SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(2)) u_sf1 (
        .clk_noc(clk), .rst_noc_sync(rst),
        .data_in(data), .dest_in(dest), .is_tail_in(tail), .send_in(send),
        .credit_out(s1_credit),
        .axis_out_tvalid(s1_tvalid), .axis_out_tready(tready),
        .axis_out_tdata(s1_tdata), .axis_out_tlast(s1_tlast),
        .axis_out_tid(s1_tid), .axis_out_tdest(s1_tdest),
        .overflow_err(s1_ovf)
    );

    noc_flit_rx_axis #(.SERIALIZATION_FACTOR(2), .FLIT_BUFFER_DEPTH(2)) u_sf2 (
        .clk_noc(clk), .rst_noc_sync(rst),
        .data_in(data), .dest_in(dest), .is_tail_in(tail), .send_in(send),
        .credit_out(s2_credit),
        .axis_out_tvalid(s2_tvalid), .axis_out_tready(tready),
        .axis_out_tdata(s2_tdata), .axis_out_tlast(s2_tlast),
        .axis_out_tid(s2_tid), .axis_out_tdest(s2_tdest),
        .overflow_err(s2_ovf)
    );

    // ---------------- scoreboard ----------------
    // Entries are {tid, tdest, tlast, tdata(64, zero-extended)}.
    logic [70:0] exp_q[$];
    logic [70:0] obs1_q[$];
    logic [70:0] obs2_q[$];
    int cred1, cred2;
    int cyc;
    int first1, last1;
    int pass_cnt;
    int total_cnt;

    // Monitor samples at the falling edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (s1_tvalid && tready) begin
            obs1_q.push_back({s1_tid, s1_tdest, s1_tlast, 32'h0, s1_tdata});
            if (first1 < 0) first1 = cyc;
            last1 = cyc;
        end
        if (s2_tvalid && tready) begin
            obs2_q.push_back({s2_tid, s2_tdest, s2_tlast, s2_tdata});
        end
        if (s1_credit) cred1 = cred1 + 1;
        if (s2_credit) cred2 = cred2 + 1;
    end

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        total_cnt = total_cnt + 1;
        if (act === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_q(input string name, input int which);
        logic [70:0] got[$];
        if (which == 1) got = obs1_q; else got = obs2_q;
        check({name, "_count"}, 71'(got.size()), 71'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check($sformatf("%s_beat%0d", name, i), got[i], exp_q[i]);
            else check($sformatf("%s_beat%0d_missing", name, i), 71'h0, exp_q[i]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs1_q.delete();
        obs2_q.delete();
        cred1  = 0;
        cred2  = 0;
        first1 = -1;
        last1  = -1;
    endtask

    task automatic do_reset();
        send = 1'b0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        tick();
        clear_sb();
    endtask

    task automatic send_flit(input logic [31:0] d, input logic [5:0] de, input logic t);
        data = d;
        dest = de;
        tail = t;
        send = 1'b1;
        tick();
        send = 1'b0;
    endtask

    // ---------------- vector table (SF=1 single-flit latency) ----------------
    typedef struct {
        logic [31:0] data;
        logic [5:0]  dest;
        logic        tail;
        logic [31:0] exp_tdata;
        logic [1:0]  exp_tid;
        logic [3:0]  exp_tdest;
        logic        exp_tlast;
    } vec_t;

    vec_t vecs[4];

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        cyc = 0;
        rst = 1'b0; data = '0; dest = '0; tail = 1'b0; send = 1'b0; tready = 1'b0;
        clear_sb();

        vecs[0] = '{32'hDEADBEEF, 6'h2B, 1'b1, 32'hDEADBEEF, 2'b10, 4'hB, 1'b1};
        vecs[1] = '{32'h12345678, 6'h05, 1'b0, 32'h12345678, 2'b00, 4'h5, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 6'h3F, 1'b1, 32'hFFFFFFFF, 2'b11, 4'hF, 1'b1};
        vecs[3] = '{32'h00000000, 6'h10, 1'b0, 32'h00000000, 2'b01, 4'h0, 1'b0};

        // ---- reset held 3 cycles while send_in=1 ----
        rst = 1'b1; send = 1'b1; data = 32'hCAFEF00D; dest = 6'h3F; tail = 1'b1;
        repeat (3) tick();
        check("rst_s1_tvalid", 71'(s1_tvalid), 71'h0);
        check("rst_s1_credit", 71'(s1_credit), 71'h0);
        check("rst_s1_tdata",  71'(s1_tdata),  71'h0);
        check("rst_s1_side",   71'({s1_tid, s1_tdest, s1_tlast}), 71'h0);
        check("rst_s1_ovf",    71'(s1_ovf),    71'h0);
        check("rst_s2_tvalid", 71'(s2_tvalid), 71'h0);
        check("rst_s2_tdata",  71'(s2_tdata),  71'h0);
        rst = 1'b0; send = 1'b0;
        repeat (3) tick();
        check("post_rst_no_push_tvalid", 71'(s1_tvalid), 71'h0);
        check("post_rst_no_push_credit", 71'(s1_credit), 71'h0);
        check("post_rst_ovf",            71'(s1_ovf),    71'h0);

        // ---- SF=1 single-flit latency table ----
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_flit(vecs[i].data, vecs[i].dest, vecs[i].tail);
            check($sformatf("v%0d_n1_tvalid", i), 71'(s1_tvalid), 71'h0);
            check($sformatf("v%0d_n1_credit", i), 71'(s1_credit), 71'h0);
            tick();
            check($sformatf("v%0d_n2_tvalid", i), 71'(s1_tvalid), 71'h1);
            check($sformatf("v%0d_n2_credit", i), 71'(s1_credit), 71'h1);
            check($sformatf("v%0d_tdata", i),     71'(s1_tdata),  71'(vecs[i].exp_tdata));
            check($sformatf("v%0d_tid", i),       71'(s1_tid),    71'(vecs[i].exp_tid));
            check($sformatf("v%0d_tdest", i),     71'(s1_tdest),  71'(vecs[i].exp_tdest));
            check($sformatf("v%0d_tlast", i),     71'(s1_tlast),  71'(vecs[i].exp_tlast));
            tick();
            check($sformatf("v%0d_n3_tvalid", i), 71'(s1_tvalid), 71'h0);
            check($sformatf("v%0d_n3_credit", i), 71'(s1_credit), 71'h0);
        end

        // ---- SF=2 full beat ----
        do_reset();
        tready = 1'b1;
        send_flit(32'h11111111, 6'h00, 1'b0);
        send_flit(32'h22222222, 6'h2B, 1'b1);
        repeat (6) tick();
        exp_q.push_back({2'b10, 4'hB, 1'b1, 64'h2222222211111111});
        compare_q("sf2_full", 2);
        check("sf2_full_credits", 71'(cred2), 71'd2);

        // ---- SF=2 odd packet: full beat then short tail beat ----
        do_reset();
        tready = 1'b1;
        send_flit(32'h0000000A, 6'h00, 1'b0);
        send_flit(32'h0000000B, 6'h35, 1'b0);
        send_flit(32'h0000000C, 6'h1C, 1'b1);
        repeat (8) tick();
        exp_q.push_back({2'b11, 4'h5, 1'b0, 64'h0000000B0000000A});
        exp_q.push_back({2'b01, 4'hC, 1'b1, 64'h000000000000000C});
        compare_q("sf2_odd", 2);
        check("sf2_odd_credits", 71'(cred2), 71'd3);

        // ---- SF=1 backpressure and overflow ----
        do_reset();
        tready = 1'b0;
        send_flit(32'h101, 6'h01, 1'b1);
        send_flit(32'h102, 6'h02, 1'b1);
        send_flit(32'h103, 6'h03, 1'b1);
        repeat (3) tick();
        check("bp_credits_full", 71'(cred1), 71'd1);
        check("bp_ovf_before",   71'(s1_ovf), 71'h0);
        check("bp_hold_tvalid",  71'(s1_tvalid), 71'h1);
        check("bp_hold_tdata",   71'(s1_tdata), 71'h101);
        tick();
        check("bp_stable_tdata", 71'(s1_tdata), 71'h101);
        send_flit(32'h104, 6'h04, 1'b1);
        check("bp_ovf_set", 71'(s1_ovf), 71'h1);
        repeat (2) tick();
        check("bp_drop_no_credit", 71'(cred1), 71'd1);
        tready = 1'b1;
        repeat (8) tick();
        exp_q.push_back({2'b00, 4'h1, 1'b1, 64'h101});
        exp_q.push_back({2'b00, 4'h2, 1'b1, 64'h102});
        exp_q.push_back({2'b00, 4'h3, 1'b1, 64'h103});
        compare_q("bp_drain", 1);
        check("bp_credits_total", 71'(cred1), 71'd3);
        check("bp_ovf_sticky",    71'(s1_ovf), 71'h1);

        // ---- SF=1 streaming, 20 back-to-back flits ----
        do_reset();
        tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data = 32'h5000 + 32'(i); dest = 6'(i % 64); tail = 1'b1; send = 1'b1;
            exp_q.push_back({6'(i % 64), 1'b1, 64'h5000 + 64'(i)});
            tick();
        end
        send = 1'b0;
        repeat (5) tick();
        compare_q("stream", 1);
        check("stream_credits", 71'(cred1), 71'd20);
        check("stream_consecutive", 71'(last1 - first1), 71'd19);

        // ---- SF=1 streaming interrupted by reset at flit 10 ----
        do_reset();
        tready = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            data = 32'h7000 + 32'(i); dest = 6'h07; tail = 1'b1; send = 1'b1;
            if (i == 10) rst = 1'b1;
            else exp_q.push_back({2'b00, 4'h7, 1'b1, 64'h7000 + 64'(i)});
            tick();
        end
        send = 1'b0;
        check("mid_rst_tvalid", 71'(s1_tvalid), 71'h0);
        check("mid_rst_credit", 71'(s1_credit), 71'h0);
        rst = 1'b0;
        repeat (6) tick();
        // Flits 9 and 10 were still in flight when reset hit.
        exp_q.delete(9);
        compare_q("mid_rst", 1);
        check("mid_rst_credits", 71'(cred1), 71'd9);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/noc_flit_rx_axis.md
Name: noc_flit_rx_axis

Overview:
- Single-clock receiving end of a router output port.
- Accepts credit-flow-controlled flits (data/dest/is_tail/send), buffers them, and returns one credit per consumed flit.
- Reassembles SERIALIZATION_FACTOR flits into one AXI-Stream beat and presents it on a registered AXIS master.
- Sits at an endpoint that attaches straight to a router port in the NoC clock domain, with no clock crossing.

Parameters:
- FLIT_WIDTH, 32, width of one flit payload.
- TID_WIDTH, 2, AXIS tid width.
- TDEST_WIDTH, 4, AXIS tdest width.
- DEST_WIDTH, TDEST_WIDTH+TID_WIDTH, flit dest field width; dest = {tid, tdest}.
- SERIALIZATION_FACTOR, 1, flits per full AXIS beat (1..8).
- TDATA_WIDTH, FLIT_WIDTH*SERIALIZATION_FACTOR, AXIS data width.
- FLIT_BUFFER_DEPTH, 2, receive FIFO depth (power of 2, ≥2). This equals the credits the sender holds after reset.

Ports:
- clk_noc  in  1  clock.
- rst_noc_sync  in  1  synchronous active-high reset.
- data_in  in  FLIT_WIDTH  flit payload.
- dest_in  in  DEST_WIDTH  flit destination {tid, tdest}.
- is_tail_in  in  1  last flit of packet.
- send_in  in  1  flit valid, one cycle per flit.
- credit_out  out  1  one-cycle credit return pulse.
- axis_out_tvalid  out  1  beat valid.
- axis_out_tready  in  1  sink ready.
- axis_out_tdata  out  TDATA_WIDTH  reassembled beat.
- axis_out_tlast  out  1  packet end.
- axis_out_tid  out  TID_WIDTH  dest_in[DEST_WIDTH-1:TDEST_WIDTH] of the beat's final flit.
- axis_out_tdest  out  TDEST_WIDTH  dest_in[TDEST_WIDTH-1:0] of the beat's final flit.
- overflow_err  out  1  sticky: flit arrived while FIFO full.

Behaviour:
- Reset: every output is 0, FIFO is empty, assembly index is 0, assembly register is 0.
- FIFO:
  - Push when send_in=1 and (not full, or a pop occurs the same cycle).
  - If send_in=1 while full with no pop, the flit is dropped and overflow_err is set until reset.
  - The FIFO read is registered: a flit pushed in cycle N is first poppable in cycle N+1.
- Assembly: index idx runs 0..SERIALIZATION_FACTOR-1.
  - A popped flit occupies bits [idx*FLIT_WIDTH +: FLIT_WIDTH] (first flit in the LSBs).
  - A flit is final when is_tail=1 or idx=SERIALIZATION_FACTOR-1.
  - Non-final flit: pops whenever the FIFO is non-empty, writes the assembly register, idx++.
  - Final flit: pops only if axis_out_tvalid=0 or axis_out_tready=1. It then loads the output register with assembly contents merged with this flit, with unfilled upper slices zero. tlast=is_tail, tid/tdest come from its dest, and idx and the assembly register clear.
  - A short beat occurs only on a tail flit.
  - When SERIALIZATION_FACTOR=1, every flit is final.
- AXIS output:
  - tvalid is held, with data/tid/tdest/tlast stable, until tready=1.
  - Load and drain in the same cycle is allowed, giving full throughput of one beat per SERIALIZATION_FACTOR cycles.
- Credits:
  - credit_out=1 in the cycle after each pop, exactly one pulse per popped flit.
  - Dropped flits return no credit.
- Latency (SF=1, idle, tready=1): send_in in cycle N gives axis_out_tvalid=1 and credit_out=1 in cycle N+2.
- Reset mid-packet: partial beat, FIFO contents and pending credit are discarded; outputs return to reset values the cycle after rst_noc_sync is sampled high.
- dest of non-final flits is ignored.

Test Plan:
- Reset check: assert rst_noc_sync for 3 cycles with send_in=1 → all outputs 0, no push, overflow_err=0.
- Single flit, SF=1: send_in at cycle 10 with data=0xDEADBEEF, dest=6'h2B, tail=1 → cycle 12 shows tvalid=1, tdata=0xDEADBEEF, tid=2'b10, tdest=4'hB, tlast=1, and credit_out pulses once.
- SF=2 full beat: flits 0x11111111 then 0x22222222 (tail), back-to-back → one beat tdata=0x2222222211111111, tlast=1, two credit pulses.
- SF=2 odd packet: flits A=0xA, B=0xB, C=0xC (tail) → beats 0x0000000B0000000A with tlast=0, then 0x000000000000000C with tlast=1.
- Backpressure and overflow, SF=1, depth 2, tready=0:
  - Send 3 flits → 1 credit pulse, FIFO full.
  - A 4th send → overflow_err=1 and that flit is dropped.
  - Raise tready → beats 1, 2, 3 delivered in order, 2 further credit pulses; overflow_err stays 1.
- Streaming and reset, SF=1, tready=1: 20 back-to-back flits → 20 consecutive beats, one credit per cycle. Asserting reset at flit 10 clears tvalid the next cycle and emits no further beats or credits.
